// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: op codes, ALU selectors, FSM states.
// Op codes 0..7 map one-to-one onto the ALU selector; 8 is a sequenced multiply.
// No logic here beyond a legality helper.
package alu_seq_pkg;

    localparam int DEFAULT_SETTLE_CYCLES = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    localparam logic [2:0] SEL_ADD  = 3'd0;
    localparam logic [2:0] SEL_SUB  = 3'd1;
    localparam logic [2:0] SEL_XOR  = 3'd2;
    localparam logic [2:0] SEL_SLT  = 3'd3;
    localparam logic [2:0] SEL_AND  = 3'd4;
    localparam logic [2:0] SEL_NAND = 3'd5;
    localparam logic [2:0] SEL_NOR  = 3'd6;
    localparam logic [2:0] SEL_OR   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_MSTEP  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_settle_timer.sv
// Settle timer: loads a cycle count and counts down, flagging the last settle cycle.
// Latency: done is high load_val cycles after the load edge (combinational from count).
// No backpressure; a new load restarts the count.
module alu_settle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign done = (cnt_q == 8'd1);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences requests onto an external multi-cycle ALU, including shift-add multiply.
// Latency: SETTLE_CYCLES edges for ALU ops, one edge for illegal ops, variable for MUL.
// Backpressure: one request in flight; response held until rsp_ready, req_ready only in IDLE.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_overflow,
    output logic        rsp_zero,
    output logic        rsp_error,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_zero
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("alu_sequencer: SETTLE_CYCLES must be in 1..255");
    end

    state_e      state_q, state_d;
    logic [3:0]  op_q;
    logic        illegal_q;
    logic [31:0] acc_q, mcand_q, mplier_q;
    logic        accept;
    logic        settle_load;
    logic        settle_done;
    logic        op_is_mul;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign accept    = req_valid && req_ready;
    assign op_is_mul = (op_q == OP_MUL);

    alu_settle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (settle_load),
        .load_val (8'(SETTLE_CYCLES)),
        .done     (settle_done)
    );

    // Illegal ops take a pass through MSTEP so the error response lands one edge
    // after acceptance, matching the zero-multiplier MUL path.
    always_comb begin
        state_d     = state_q;
        settle_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_op <= OP_OR) begin
                        state_d     = ST_SETTLE;
                        settle_load = 1'b1;
                    end else begin
                        state_d = ST_MSTEP;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    state_d = op_is_mul ? ST_MSTEP : ST_RESP;
                end
            end
            ST_MSTEP: begin
                if (illegal_q || mplier_q == 32'd0) begin
                    state_d = ST_RESP;
                end else if (mplier_q[0]) begin
                    state_d     = ST_SETTLE;
                    settle_load = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= 4'd0;
            illegal_q    <= 1'b0;
            acc_q        <= 32'd0;
            mcand_q      <= 32'd0;
            mplier_q     <= 32'd0;
            alu_a        <= 32'd0;
            alu_b        <= 32'd0;
            alu_sel      <= SEL_ADD;
            rsp_result   <= 32'd0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_error    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= req_op;
                        illegal_q <= !op_is_legal(req_op);
                        if (req_op == OP_MUL) begin
                            acc_q    <= 32'd0;
                            mcand_q  <= req_a;
                            mplier_q <= req_b;
                        end else if (req_op <= OP_OR) begin
                            alu_a   <= req_a;
                            alu_b   <= req_b;
                            alu_sel <= req_op[2:0];
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        if (op_is_mul) begin
                            // Partial-product add: ALU carry and bits past 31 are dropped.
                            acc_q    <= alu_out;
                            mcand_q  <= mcand_q << 1;
                            mplier_q <= mplier_q >> 1;
                        end else begin
                            rsp_result   <= alu_out;
                            rsp_carry    <= alu_carry;
                            rsp_overflow <= alu_overflow;
                            rsp_zero     <= alu_zero;
                            rsp_error    <= 1'b0;
                        end
                    end
                end
                ST_MSTEP: begin
                    if (illegal_q) begin
                        rsp_result   <= 32'd0;
                        rsp_carry    <= 1'b0;
                        rsp_overflow <= 1'b0;
                        rsp_zero     <= 1'b0;
                        rsp_error    <= 1'b1;
                    end else if (mplier_q == 32'd0) begin
                        rsp_result   <= acc_q;
                        rsp_carry    <= 1'b0;
                        rsp_overflow <= 1'b0;
                        rsp_zero     <= (acc_q == 32'd0);
                        rsp_error    <= 1'b0;
                    end else if (mplier_q[0]) begin
                        alu_a   <= acc_q;
                        alu_b   <= mcand_q;
                        alu_sel <= SEL_ADD;
                    end else begin
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model on the alu_* port.
// Expected values are hand-computed per vector.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carry, rsp_overflow, rsp_zero, rsp_error;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_out;
    logic        alu_carry, alu_overflow, alu_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_error    (rsp_error),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_out      (alu_out),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero)
    );

    // Reference ALU; SUB carry is the no-borrow flag (a + ~b + 1).
    logic [32:0] sum;
    always_comb begin
        sum          = 33'd0;
        alu_out      = 32'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_sel)
            3'd0: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out      = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            3'd1: begin
                sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_out      = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
            end
            3'd2: alu_out = alu_a ^ alu_b;
            3'd3: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'd4: alu_out = alu_a & alu_b;
            3'd5: alu_out = ~(alu_a & alu_b);
            3'd6: alu_out = ~(alu_a | alu_b);
            default: alu_out = alu_a | alu_b;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 500) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input logic c, input logic o, input logic z, input logic e);
        int lat;
        send(op, a, b);
        wait_rsp(lat);
        if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, rsp_result, exp_res);
        check({tag, "_flags"}, {rsp_carry, rsp_overflow, rsp_zero, rsp_error}, {c, o, z, e});
        consume();
        check({tag, "_idle"}, {req_ready, rsp_valid}, 2'b10);
    endtask

    initial begin
        int lat;
        int stale;
        reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_rspv", rsp_valid, 0);
        check("rst_res", rsp_result, 0);
        check("rst_flags", {rsp_carry, rsp_overflow, rsp_zero, rsp_error}, 0);
        check("rst_alu", {alu_a ^ alu_b, 29'd0, alu_sel}, 0);
        @(negedge clk) reset = 1'b0;

        //      tag      op     a             b             lat res           c  o  z  e
        run_op("add",    4'd0, 32'd10,       32'd1,        4,  32'd11,       0, 0, 0, 0);
        check("add_alu_hold", {alu_a, alu_b}, {32'd10, 32'd1});
        run_op("sub_neg", 4'd1, 32'd0,       32'd1,        4,  32'hFFFFFFFF, 0, 0, 0, 0);
        run_op("sub_eq", 4'd1,  32'd5,       32'd5,        4,  32'd0,        1, 0, 1, 0);
        run_op("add_ovf", 4'd0, 32'h7FFFFFFF, 32'd1,       4,  32'h80000000, 0, 1, 0, 0);
        run_op("add_cy", 4'd0,  32'hFFFFFFFF, 32'd1,       4,  32'd0,        1, 0, 1, 0);
        run_op("slt",    4'd3,  32'hFFFFFFFF, 32'd1,       4,  32'd1,        0, 0, 0, 0);
        run_op("xor",    4'd2,  32'h0000F0F0, 32'h000000FF, 4, 32'h0000F00F, 0, 0, 0, 0);
        run_op("and",    4'd4,  32'hC,        32'hA,       4,  32'h8,        0, 0, 0, 0);
        run_op("nand",   4'd5,  32'hC,        32'hA,       4,  32'hFFFFFFF7, 0, 0, 0, 0);
        run_op("nor",    4'd6,  32'hC,        32'hA,       4,  32'hFFFFFFF1, 0, 0, 0, 0);
        run_op("or",     4'd7,  32'hC,        32'hA,       4,  32'hE,        0, 0, 0, 0);
        run_op("mul35",  4'd8,  32'd3,        32'd5,       12, 32'd15,       0, 0, 0, 0);
        // Last ALU drive of 3*5 was acc=3 + mcand=12.
        check("mul35_alu", {alu_a, alu_b}, {32'd3, 32'd12});
        run_op("mul_b0", 4'd8,  32'd7,        32'd0,       1,  32'd0,        0, 0, 1, 0);
        check("mul_b0_alu", {alu_a, alu_b}, {32'd3, 32'd12});
        run_op("mul_wrap", 4'd8, 32'h10000,   32'h10000,   22, 32'd0,        0, 0, 1, 0);
        run_op("mul_ff", 4'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'd1,       0, 0, 0, 0);

        run_op("pre_ill", 4'd2, 32'h1234,     32'h00FF,    4,  32'h12CB,     0, 0, 0, 0);
        run_op("illegal", 4'd12, 32'hAAAA,    32'h5555,    1,  32'd0,        0, 0, 0, 1);
        check("ill_alu", {alu_a, alu_b}, {32'h1234, 32'h00FF});
        check("ill_sel", alu_sel, 3'd2);

        // Held response under backpressure, with a competing request offered.
        send(4'd0, 32'd2, 32'd3);
        wait_rsp(lat);
        check("bp_lat", lat, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_op = 4'd1; req_a = 32'd100; req_b = 32'd1;
            check("bp_hold", {rsp_valid, req_ready, rsp_result}, {2'b10, 32'd5});
        end
        consume();
        req_valid = 1'b0;
        check("bp_release", {req_ready, rsp_valid}, 2'b10);
        check("bp_res_keep", rsp_result, 32'd5);
        check("bp_alu_keep", {alu_a, alu_b}, {32'd2, 32'd3});

        // Reset in the middle of a multiply settle window.
        send(4'd8, 32'd3, 32'd5);
        @(posedge clk);
        @(posedge clk);
        #1 check("mid_alu_b", alu_b, 32'd3);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ctl", {req_ready, rsp_valid}, 2'b10);
        check("mid_rst_alu", {alu_a, alu_b}, 64'd0);
        check("mid_rst_sel", alu_sel, 3'd0);
        @(negedge clk) reset = 1'b0;
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        check("mid_no_stale", stale, 0);

        // Reset beats a simultaneous response handshake and a simultaneous accept.
        send(4'd0, 32'd20, 32'd22);
        wait_rsp(lat);
        @(negedge clk);
        rsp_ready = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1;
        check("prio_rsp", {req_ready, rsp_valid, rsp_result}, {2'b10, 32'd0});
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'd9; req_b = 32'd9;
        @(posedge clk);
        #1;
        check("prio_acc", {req_ready, alu_a}, {1'b1, 32'd0});
        @(negedge clk);
        req_valid = 1'b0; reset = 1'b0;
        run_op("post_rst", 4'd0, 32'd1, 32'd2, 4, 32'd3, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, cycles the ALU inputs are held before sampling; legal range 1..255, elaboration error otherwise.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 req_valid  in  1  request offered.
REQ-005 req_ready  out  1  sequencer can accept.
REQ-006 req_op  in  4  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MUL (low 32 bits); 9..15 illegal.
REQ-007 req_a, req_b  in  32 each  operands.
REQ-008 rsp_valid  out  1  response available.
REQ-009 rsp_ready  in  1  consumer accepts response.
REQ-010 rsp_result  out  32  result; rsp_carry, rsp_overflow, rsp_zero, rsp_error  out  1 each.
REQ-011 alu_a, alu_b  out  32; alu_sel  out  3  drive to ALU (ALU selector encoding = req_op[2:0]).
REQ-012 alu_out  in  32; alu_carry, alu_overflow, alu_zero  in  1 each  ALU results.

Function
REQ-013 States: IDLE, SETTLE, MSTEP, RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 Accept on req_valid&&req_ready; latch op, a, b at that edge.
REQ-015 op 0..7: next state SETTLE; alu_a=a, alu_b=b, alu_sel=op[2:0] held stable for exactly SETTLE_CYCLES cycles.
REQ-016 At the edge ending the last SETTLE cycle, alu_out and the three ALU flags SHALL be captured into rsp_* and state -> RESP; rsp_error=0.
REQ-017 Single-op latency: rsp_valid high after exactly SETTLE_CYCLES edges following the accepting edge.
REQ-018 op 8: acc=0, mcand=a, mplier=b; next state MSTEP.
REQ-019 MSTEP, mplier==0: -> RESP, rsp_result=acc, carry=0, overflow=0, zero=(acc==0), error=0.
REQ-020 MSTEP, mplier[0]==0: mcand<<=1, mplier>>=1, stay MSTEP.
REQ-021 MSTEP, mplier[0]==1: -> SETTLE with alu_a=acc, alu_b=mcand, alu_sel=ADD; at capture acc<=alu_out, mcand<<=1, mplier>>=1, return to MSTEP; ALU carry ignored, bits above 31 discarded.
REQ-022 op 9..15: next edge -> RESP with rsp_result=0, all flags 0, rsp_error=1; alu_* outputs unchanged.
REQ-023 RESP: rsp_valid=1 and all rsp_* stable until rsp_valid&&rsp_ready; then -> IDLE; no same-cycle re-accept.
REQ-024 alu_a/alu_b/alu_sel SHALL change only on entry to SETTLE; otherwise hold last value.
REQ-025 rsp_* SHALL hold last value outside RESP; rsp_valid=0 outside RESP.

Reset
REQ-026 On reset edge: state IDLE, req_ready=1 next cycle, rsp_valid=0, rsp_result=0, all rsp flags 0, alu_a=alu_b=0, alu_sel=0, counter/acc/mcand/mplier=0.
REQ-027 Reset mid-operation (any state) SHALL abandon the operation; no response is produced for it.
REQ-028 Reset has priority over any simultaneous handshake.

Structure
REQ-029 Shared package alu_seq_pkg: op codes (4-bit, 0..8), ALU selector codes, state enum, default SETTLE_CYCLES.
REQ-030 One sub-module alu_settle_timer: 8-bit load/down-counter asserting done on the last settle cycle.

Verification
REQ-031 ADD a=10, b=1, SETTLE=4 -> rsp_result=11, carry=0, overflow=0, zero=0, rsp_valid after 4 edges.
REQ-032 SUB a=0, b=1 -> rsp_result=0xFFFFFFFF, carry=0, zero=0; SUB a=5, b=5 -> result 0, zero=1, carry=1.
REQ-033 MUL a=3, b=5, SETTLE=4 -> rsp_result=15, rsp_valid after 12 edges; MUL b=0 -> result 0, zero=1 after 1 edge; MUL a=0x10000, b=0x10000 -> result 0.
REQ-034 op=12 -> rsp_error=1, result 0, after 1 edge, alu_* unchanged.
REQ-035 rsp_ready held 0 for 10 cycles -> rsp_* stable, req_ready=0; rsp_ready=1 -> IDLE next edge.
REQ-036 reset asserted mid-MUL SETTLE -> next cycle req_ready=1, rsp_valid=0, alu_*=0; no stale response follows.
